// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: start/busy/done request bundle and HI/LO read-out
// for the iterative multiply/divide unit.
interface muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, A, B,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, A, B,
      output busy, done, div_by_zero, hi, lo
   );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO into HI/LO.
// One multiplier or quotient bit per cycle; WIDTH cycles per op.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input logic          clk,
   input logic          rst_n,
   muldiv_unit_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam int W2 = 2 * WIDTH;

   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_nxt;

   logic [W2-1:0]    acc, acc_nxt, prod;
   logic [WIDTH-1:0] opb, hi_q, lo_q;
   logic [WIDTH-1:0] a_abs, b_abs, quo, rem;
   logic [WIDTH-1:0] hi_res, lo_res;
   logic [WIDTH:0]   sum, shifted, diff;
   logic [CW-1:0]    cnt;
   logic             is_div, neg_q, neg_r, dbz;
   logic             done_q, dbz_q;
   logic             a_neg, b_neg, idle, last;
   logic             go_md, go_mthi, go_mtlo;

   assign idle  = (state == IDLE);
   assign last  = (cnt == CW'(WIDTH - 1));
   assign a_neg = ~bus.op[0] & bus.A[WIDTH-1];
   assign b_neg = ~bus.op[0] & bus.B[WIDTH-1];
   assign a_abs = a_neg ? -bus.A : bus.A;
   assign b_abs = b_neg ? -bus.B : bus.B;

   // Classify an accepted request; reserved codes fall through.
   always_comb begin
      go_md   = 1'b0;
      go_mthi = 1'b0;
      go_mtlo = 1'b0;
      if (bus.start && idle) begin
         unique case (1'b1)
            !bus.op[2]:         go_md   = 1'b1;
            bus.op == 3'b100:   go_mthi = 1'b1;
            bus.op == 3'b101:   go_mtlo = 1'b1;
            default: ;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state: run for WIDTH iterations after an accepted mul/div.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (go_md) state_nxt = RUN;
         RUN:  if (last)  state_nxt = IDLE;
      endcase
   end

   // Outputs: busy from state, the rest from registers.
   always_comb begin
      bus.busy        = (state == RUN);
      bus.done        = done_q;
      bus.div_by_zero = dbz_q;
      bus.hi          = hi_q;
      bus.lo          = lo_q;
   end

   // One iteration: shift-add multiply or restoring divide step.
   // A zero divisor forces quotient ones and leaves |A| in rem.
   always_comb begin
      sum     = {1'b0, acc[W2-1:WIDTH]}
              + {1'b0, acc[0] ? opb : {WIDTH{1'b0}}};
      shifted = acc[W2-1:WIDTH-1];
      diff    = shifted - {1'b0, opb};
      if (!is_div)
         acc_nxt = {sum, acc[WIDTH-1:1]};
      else if (!diff[WIDTH] || dbz)
         acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
         acc_nxt = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
   end

   // Sign fix-up of the final iteration's result.
   always_comb begin
      prod = neg_q ? -acc_nxt : acc_nxt;
      rem  = acc_nxt[W2-1:WIDTH];
      quo  = acc_nxt[WIDTH-1:0];
      if (is_div) begin
         hi_res = neg_r ? -rem : rem;
         lo_res = dbz ? {WIDTH{1'b1}} : (neg_q ? -quo : quo);
      end else begin
         hi_res = prod[W2-1:WIDTH];
         lo_res = prod[WIDTH-1:0];
      end
   end

   // Operand latch, iteration, HI/LO writes and completion pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         opb    <= '0;
         cnt    <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         dbz    <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
         dbz_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         dbz_q  <= 1'b0;
         if (go_md) begin
            acc    <= {{WIDTH{1'b0}}, bus.op[1] ? a_abs : b_abs};
            opb    <= bus.op[1] ? b_abs : a_abs;
            cnt    <= '0;
            is_div <= bus.op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            dbz    <= bus.op[1] & ~|bus.B;
         end else if (state == RUN) begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (last) begin
               hi_q   <= hi_res;
               lo_q   <= lo_res;
               done_q <= 1'b1;
               dbz_q  <= dbz;
            end
         end
         if (go_mthi) begin
            hi_q   <= bus.A;
            done_q <= 1'b1;
         end
         if (go_mtlo) begin
            lo_q   <= bus.A;
            done_q <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit at
// WIDTH=32 and WIDTH=8 against an arithmetic reference model.
module tb_muldiv_unit;
   localparam logic [2:0] MULT  = 3'b000;
   localparam logic [2:0] MULTU = 3'b001;
   localparam logic [2:0] DIV   = 3'b010;
   localparam logic [2:0] DIVU  = 3'b011;
   localparam logic [2:0] MTHI  = 3'b100;
   localparam logic [2:0] MTLO  = 3'b101;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sel = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'b000;
   logic [31:0] a_drv = '0;
   logic [31:0] b_drv = '0;
   logic [31:0] ref_hi = '0;
   logic [31:0] ref_lo = '0;
   int          w = 32;
   int          n_tests = 0;
   int          n_fail = 0;

   logic        obs_busy, obs_done, obs_dbz;
   logic [31:0] obs_hi, obs_lo;

   always #5 clk = ~clk;

   muldiv_unit_if #(.WIDTH(32)) bus32 ();
   muldiv_unit_if #(.WIDTH(8))  bus8 ();

   muldiv_unit #(.WIDTH(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .bus(bus32.slave));
   muldiv_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .bus(bus8.slave));

   assign bus32.start = start & ~sel;
   assign bus32.op    = op;
   assign bus32.A     = a_drv;
   assign bus32.B     = b_drv;
   assign bus8.start  = start & sel;
   assign bus8.op     = op;
   assign bus8.A      = a_drv[7:0];
   assign bus8.B      = b_drv[7:0];

   assign obs_busy = sel ? bus8.busy : bus32.busy;
   assign obs_done = sel ? bus8.done : bus32.done;
   assign obs_dbz  = sel ? bus8.div_by_zero : bus32.div_by_zero;
   assign obs_hi   = sel ? {24'd0, bus8.hi} : bus32.hi;
   assign obs_lo   = sel ? {24'd0, bus8.lo} : bus32.lo;

   function automatic logic [31:0] msk();
      return (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
   endfunction

   // Plain-arithmetic reference for one mul/div at width w.
   function automatic void model(input logic [2:0] o,
                                 input logic [31:0] a, b,
                                 output logic [31:0] eh, el,
                                 output logic ez);
      longint      m, ua, ub, sa, sb, q, r;
      logic [63:0] p;
      m  = (longint'(1) << w) - 1;
      ua = longint'(a) & m;
      ub = longint'(b) & m;
      sa = ua;
      sb = ub;
      if ((ua >> (w - 1)) != 0) sa = ua - (m + 1);
      if ((ub >> (w - 1)) != 0) sb = ub - (m + 1);
      p  = '0;
      eh = '0;
      el = '0;
      ez = 1'b0;
      if (o == MULT || o == MULTU) begin
         if (o == MULT) p = sa * sb;
         else           p = ua * ub;
         el = 32'(p & m);
         eh = 32'((p >> w) & m);
      end else if (ub == 0) begin
         el = 32'(m);
         eh = 32'(ua);
         ez = 1'b1;
      end else begin
         if (o == DIV) begin
            q = sa / sb;
            r = sa % sb;
         end else begin
            q = ua / ub;
            r = ua % ub;
         end
         el = 32'(q & m);
         eh = 32'(r & m);
      end
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Present a request for the current cycle, then scramble operands.
   task automatic issue(input logic [2:0] o, input logic [31:0] a, b);
      start = 1'b1;
      op    = o;
      a_drv = a;
      b_drv = b;
      cyc();
      start = 1'b0;
      op    = 3'($urandom_range(7));
      a_drv = $urandom;
      b_drv = $urandom;
   endtask

   // Count busy cycles up to done; optionally poke a DIV start.
   task automatic wait_done(input int poke, output int nb,
                            output bit seen);
      nb   = 0;
      seen = 1'b0;
      for (int i = 0; i < 80; i++) begin
         if (obs_done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (obs_busy === 1'b1) nb++;
         start = (i == poke);
         if (i == poke) begin
            op    = DIV;
            a_drv = $urandom;
            b_drv = $urandom;
         end
         cyc();
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      int nb;
      bit seen;
      rst_n = 1'b0;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if (obs_busy !== 0 || obs_done !== 0 || obs_dbz !== 0 ||
          obs_hi !== 0 || obs_lo !== 0) begin
         n_fail++;
         $display("FAIL reset_state: busy=%0b done=%0b dbz=%0b hi=%h lo=%h, want all 0",
                  obs_busy, obs_done, obs_dbz, obs_hi, obs_lo);
      end
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      issue(MTHI, 32'hA5A5_A5A5, 32'h0);
      issue(MTLO, 32'h5A5A_5A5A, 32'h0);
      issue(MULTU, $urandom, $urandom);
      repeat (3) cyc();
      n_tests++;
      if (obs_busy !== 1 || obs_hi !== (32'hA5A5_A5A5 & msk()) ||
          obs_lo !== (32'h5A5A_5A5A & msk())) begin
         n_fail++;
         $display("FAIL pre_reset: busy=%0b hi=%h lo=%h, want busy=1 hi=%h lo=%h",
                  obs_busy, obs_hi, obs_lo,
                  32'hA5A5_A5A5 & msk(), 32'h5A5A_5A5A & msk());
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (obs_busy !== 0 || obs_hi !== 0 || obs_lo !== 0 || obs_done !== 0) begin
         n_fail++;
         $display("FAIL midrun_reset: busy=%0b done=%0b hi=%h lo=%h, want 0",
                  obs_busy, obs_done, obs_hi, obs_lo);
      end
      @(negedge clk);
      rst_n = 1'b1;
      ref_hi = '0;
      ref_lo = '0;
      nb = 0;
      for (int i = 0; i < w + 4; i++) begin
         cyc();
         if (obs_done !== 0 || obs_busy !== 0) nb++;
      end
      n_tests++;
      if (nb != 0) begin
         n_fail++;
         $display("FAIL post_reset_quiet: %0d active cycles, want 0", nb);
      end
   endtask

   task automatic test_mt();
      int bad;
      bad = 0;
      issue(MTHI, 32'hDEAD_BEEF, $urandom);
      ref_hi = 32'hDEAD_BEEF & msk();
      n_tests++;
      if (obs_done !== 1 || obs_busy !== 0 || obs_hi !== ref_hi) begin
         n_fail++;
         $display("FAIL mthi: done=%0b busy=%0b hi=%h, want done=1 busy=0 hi=%h",
                  obs_done, obs_busy, obs_hi, ref_hi);
      end
      issue(MTLO, 32'h1, $urandom);
      ref_lo = 32'h1;
      n_tests++;
      if (obs_done !== 1 || obs_busy !== 0 || obs_lo !== ref_lo ||
          obs_hi !== ref_hi) begin
         n_fail++;
         $display("FAIL mtlo: done=%0b busy=%0b hi=%h lo=%h, want done=1 busy=0 hi=%h lo=%h",
                  obs_done, obs_busy, obs_hi, obs_lo, ref_hi, ref_lo);
      end
      cyc();
      n_tests++;
      if (obs_done !== 0 || obs_busy !== 0) begin
         n_fail++;
         $display("FAIL mt_pulse: done=%0b busy=%0b, want 0 0",
                  obs_done, obs_busy);
      end
   endtask

   task automatic test_directed();
      logic [2:0]  ops [6];
      logic [31:0] as [6];
      logic [31:0] bs [6];
      logic [31:0] eh, el, mn;
      logic        ez;
      int          nb;
      bit          seen;
      mn  = 32'h1 << (w - 1);
      ops = '{MULT, MULTU, DIV, DIVU, DIVU, DIV};
      as  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
              32'd100, 32'h1234, mn};
      bs  = '{32'd5, 32'hFFFF_FFFF, 32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF};
      for (int i = 0; i < 6; i++) begin
         model(ops[i], as[i], bs[i], eh, el, ez);
         issue(ops[i], as[i], bs[i]);
         wait_done(-1, nb, seen);
         n_tests++;
         if (!seen || nb != w || obs_busy !== 0) begin
            n_fail++;
            $display("FAIL dir%0d_latency: busy %0d cycles done=%0b, want %0d and done",
                     i, nb, seen, w);
         end
         n_tests++;
         if (obs_hi !== eh || obs_lo !== el || obs_dbz !== ez) begin
            n_fail++;
            $display("FAIL dir%0d_result: hi=%h lo=%h dbz=%0b, want hi=%h lo=%h dbz=%0b",
                     i, obs_hi, obs_lo, obs_dbz, eh, el, ez);
         end
         ref_hi = eh;
         ref_lo = el;
         cyc();
         n_tests++;
         if (obs_done !== 0 || obs_dbz !== 0 || obs_hi !== eh) begin
            n_fail++;
            $display("FAIL dir%0d_pulse: done=%0b dbz=%0b hi=%h, want 0 0 %h",
                     i, obs_done, obs_dbz, obs_hi, eh);
         end
      end
   endtask

   task automatic test_random();
      logic [2:0]  o;
      logic [31:0] a, b, eh, el;
      logic        ez;
      int          nb, r;
      bit          seen;
      for (int i = 0; i < 25; i++) begin
         o = 3'($urandom_range(3));
         a = $urandom;
         b = $urandom;
         r = $urandom_range(7);
         if (r == 0) b = '0;
         if (r == 1) begin
            a = 32'h1 << (w - 1);
            b = 32'hFFFF_FFFF;
         end
         model(o, a, b, eh, el, ez);
         issue(o, a, b);
         wait_done(-1, nb, seen);
         n_tests++;
         if (!seen || nb != w || obs_hi !== eh || obs_lo !== el ||
             obs_dbz !== ez) begin
            n_fail++;
            $display("FAIL rnd%0d op%0d a=%h b=%h: cyc=%0d hi=%h lo=%h dbz=%0b, want cyc=%0d hi=%h lo=%h dbz=%0b",
                     i, o, a, b, nb, obs_hi, obs_lo, obs_dbz, w, eh, el, ez);
         end
         ref_hi = eh;
         ref_lo = el;
         cyc();
      end
   endtask

   task automatic test_busy_start();
      logic [31:0] a, b, eh, el;
      logic        ez;
      int          nb;
      bit          seen;
      a = $urandom;
      b = $urandom;
      model(MULT, a, b, eh, el, ez);
      issue(MULT, a, b);
      wait_done(3, nb, seen);
      n_tests++;
      if (!seen || nb != w || obs_hi !== eh || obs_lo !== el ||
          obs_dbz !== 0) begin
         n_fail++;
         $display("FAIL busy_start: cyc=%0d hi=%h lo=%h dbz=%0b, want cyc=%0d hi=%h lo=%h dbz=0",
                  nb, obs_hi, obs_lo, obs_dbz, w, eh, el);
      end
      ref_hi = eh;
      ref_lo = el;
      cyc();
      n_tests++;
      if (obs_busy !== 0 || obs_done !== 0) begin
         n_fail++;
         $display("FAIL busy_start_idle: busy=%0b done=%0b, want 0 0",
                  obs_busy, obs_done);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0]  o1, o2;
      logic [31:0] a1, b1, a2, b2, eh1, el1, eh2, el2;
      logic        ez1, ez2;
      int          nb;
      bit          seen;
      o1 = 3'($urandom_range(3));
      o2 = 3'($urandom_range(3));
      a1 = $urandom;
      b1 = $urandom;
      a2 = $urandom;
      b2 = $urandom;
      model(o1, a1, b1, eh1, el1, ez1);
      model(o2, a2, b2, eh2, el2, ez2);
      issue(o1, a1, b1);
      wait_done(-1, nb, seen);
      n_tests++;
      if (!seen || obs_hi !== eh1 || obs_lo !== el1) begin
         n_fail++;
         $display("FAIL b2b_first: done=%0b hi=%h lo=%h, want done hi=%h lo=%h",
                  seen, obs_hi, obs_lo, eh1, el1);
      end
      issue(o2, a2, b2);
      wait_done(-1, nb, seen);
      n_tests++;
      if (!seen || nb != w || obs_hi !== eh2 || obs_lo !== el2 ||
          obs_dbz !== ez2) begin
         n_fail++;
         $display("FAIL b2b_second: cyc=%0d hi=%h lo=%h dbz=%0b, want cyc=%0d hi=%h lo=%h dbz=%0b",
                  nb, obs_hi, obs_lo, obs_dbz, w, eh2, el2, ez2);
      end
      ref_hi = eh2;
      ref_lo = el2;
      cyc();
   endtask

   task automatic test_reserved();
      logic [2:0] rsv [2];
      int         act;
      rsv = '{3'b111, 3'b110};
      for (int i = 0; i < 2; i++) begin
         issue(rsv[i], $urandom, $urandom);
         act = 0;
         for (int k = 0; k < 5; k++) begin
            if (obs_done !== 0 || obs_busy !== 0 ||
                obs_hi !== ref_hi || obs_lo !== ref_lo) act++;
            cyc();
         end
         n_tests++;
         if (act != 0) begin
            n_fail++;
            $display("FAIL reserved_%b: %0d bad cycles hi=%h lo=%h, want 0 and hi=%h lo=%h",
                     rsv[i], act, obs_hi, obs_lo, ref_hi, ref_lo);
         end
      end
   endtask

   task automatic run_suite(input logic s);
      sel = s;
      w   = s ? 8 : 32;
      test_reset();
      test_mt();
      test_directed();
      test_random();
      test_busy_start();
      test_back_to_back();
      test_reserved();
   endtask

   initial begin
      run_suite(1'b0);
      run_suite(1'b1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit for the MIPS datapath, the sequential companion to the combinational ALU. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO into an internal HI/LO register pair. It uses a start/busy/done handshake so the pipeline can stall on HI/LO consumers. Width is generic; a multiply or divide takes WIDTH cycles.

## Interface
- WIDTH, 32, operand width in bits; legal values are 4 or greater.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock; asynchronous, active-low.
- start  input  1  request strobe; sampled only while busy=0.
- op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are reserved.
- A  input  WIDTH  multiplicand / dividend / MTHI-MTLO source.
- B  input  WIDTH  multiplier / divisor.
- busy  output  1  iteration in progress.
- done  output  1  one-cycle completion pulse.
- div_by_zero  output  1  asserted together with done for DIV/DIVU with B=0.
- hi  output  WIDTH  HI register (MULT high product; DIV remainder).
- lo  output  WIDTH  LO register (MULT low product; DIV quotient).

## Operation
- States: IDLE and RUN.
- IDLE, start=1, op=MULT/MULTU/DIV/DIVU:
  - latch operand magnitudes; signed ops take the two's-complement absolute value.
  - latch result-sign flags and op; clear the iteration counter; go to RUN.
- IDLE, start=1, op=MTHI or MTLO: write A into hi or lo at the same edge; done=1 next cycle; stay IDLE; busy never rises.
- IDLE, start=1, reserved op: ignored; no done, no register change.
- RUN, multiply: shift-add, one multiplier bit per cycle into a 2*WIDTH accumulator.
- RUN, divide: restoring division, one quotient bit per cycle.
- RUN end: after WIDTH iterations, apply the sign fix-up and write hi/lo in the same edge that leaves RUN.
- Signed results:
  - product is negated if the operand signs differ.
  - quotient is negated if the signs differ.
  - remainder takes the dividend's sign.
- Width rule: the 2*WIDTH-bit product is exact (no overflow); the quotient and remainder are truncated to WIDTH bits.
- DIV of -2^(WIDTH-1) by -1: lo=-2^(WIDTH-1), hi=0; no flag.
- Divide by zero (DIV/DIVU, B=0):
  - full WIDTH-cycle latency is kept.
  - lo=all ones, hi=A (as latched), div_by_zero=1 with done.
- start while busy=1 is ignored; the in-flight op is unaffected.
- hi/lo hold their value until the next MT* write or multiply/divide completion.

## Timing
- Reset (asynchronous, any time, including mid-RUN):
  - state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0; counter and accumulators cleared.
  - the in-flight op is abandoned.
- Multiply/divide accepted at edge k:
  - busy=1 during cycles k+1..k+WIDTH.
  - hi/lo update and busy falls at edge k+WIDTH; done=1 for cycle k+WIDTH+1... see note below.
  - Precisely: done is registered and high in the cycle following the final edge, i.e. the cycle in which busy is first 0 again.
- A new start may be sampled in the same cycle that done=1 (back-to-back ops).
- MT* accepted at edge k: hi/lo visible and done=1 in the cycle after edge k.
- A and B only need to be valid in the start cycle.
- done and div_by_zero are single-cycle pulses, never held.

## Test plan
- Reset: assert rst_n=0 mid-RUN of a MULTU -> busy=0, hi=lo=0 immediately; after release, no done pulse occurs.
- MULT, WIDTH=32, A=-3, B=5 -> busy for 32 cycles, then done for 1 cycle, hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV A=-7, B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU A=100, B=7 -> lo=14, hi=2.
- Divide boundaries:
  - DIVU A=0x1234, B=0 -> done with div_by_zero=1, lo=0xFFFFFFFF, hi=0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- Handshake:
  - start=1 with op=DIV during busy -> ignored; the original MULT result and timing are unchanged.
  - a new start in the done cycle is accepted and completes 32 cycles later.
- MTHI A=0xDEADBEEF, then MTLO A=0x1 on consecutive cycles -> each gives done after 1 cycle and busy stays 0, hi=0xDEADBEEF, lo=0x1. Reserved op 3'b111 -> no done and registers unchanged. Repeat the suite with WIDTH=8.
